dmem_responder: RTL and testbench

Memory-side responder for the data-memory port. It accepts one aligned word request per transaction: a word address, a 32-bit lane-aligned write word, and a 4-bit byte-lane write mask, exactly as the processor's store-alignment stage produces them. Writes commit only the enabled byte lanes. Reads return the full 32-bit word, which the processor's load-alignment stage then slices and extends. The block sits between the core's load/store unit and an internal word-organised RAM, with a configurable number of wait states and a valid/ready handshake on both request and response.

---
 rtl/dmem_responder_if.sv | 35 +++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the core's load/store unit (master) and
// the data-memory responder (slave).
//   req_valid  master->slave  request present
//   req_ready  slave->master  responder can accept a request
//   req_addr   master->slave  byte address (bits [1:0] ignored)
//   req_wdata  master->slave  lane-aligned write word
//   req_mask   master->slave  byte-lane write enables, 0 means read
//   rsp_valid  slave->master  response present
//   rsp_ready  master->slave  consumer takes the response
//   rsp_rdata  slave->master  read word (0 for writes and errors)
//   rsp_err    slave->master  address out of range
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the data-memory port. Accepts one word request
// at a time, inserts WAIT_CYC wait states, then commits the access to an
// internal byte-lane RAM and presents a registered response.
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset (RAM contents are not cleared)
//   bus   dmem_responder_if.slave: request/response handshake bundle
// Parameters:
//   ADDR_W    word-address width, RAM depth 2^ADDR_W x 32 bits
//   WAIT_CYC  wait states between acceptance and response (0..15)
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_responder_if.slave        bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_INIT_I = (WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0;
  localparam logic [3:0] CNT_INIT = 4'(CNT_INIT_I);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:2] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_commit;
  logic              w_oor;
  logic              w_is_rd;
  logic              w_wr_en;
  logic [31:2]       w_cur_addr;
  logic [31:0]       w_cur_wdata;
  logic [3:0]        w_cur_mask;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rd_word;

  // No path from req_valid: ready depends only on state and reset.
  assign w_req_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept    = bus.req_valid & w_req_ready;

  // With zero wait states the commit happens on the accepting edge, so the
  // live request fields are used; otherwise the latched copies are.
  assign w_cur_addr  = (r_state == S_IDLE) ? bus.req_addr[31:2] : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? bus.req_wdata      : r_wdata;
  assign w_cur_mask  = (r_state == S_IDLE) ? bus.req_mask       : r_mask;

  assign w_idx = w_cur_addr[ADDR_W+1:2];
  assign w_oor = |w_cur_addr[31:ADDR_W+2];

  // Commit on the edge that enters RESP; reset on that edge cancels it.
  assign w_commit = ~rst & (((r_state == S_IDLE) & w_accept & (WAIT_CYC == 0)) |
                            ((r_state == S_WAIT) & (r_cnt == 4'd0)));
  assign w_wr_en  = w_commit & ~w_oor & (|w_cur_mask);
  assign w_is_rd  = ~w_oor & ~(|w_cur_mask);

  // One byte-wide RAM per lane so each mask bit is an independent write enable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (w_wr_en && w_cur_mask[gi]) begin
          r_mem[w_idx] <= w_cur_wdata[8*gi +: 8];
        end
      end

      assign w_rd_word[8*gi +: 8] = r_mem[w_idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      // Response registers are loaded once at commit and then held in RESP.
      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_oor;
        r_rsp_rdata <= w_is_rd ? w_rd_word : 32'h0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= bus.req_addr[31:2];
            r_wdata <= bus.req_wdata;
            r_mask  <= bus.req_mask;
            if (WAIT_CYC == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Two responders: u_dut with WAIT_CYC=1 for the main vector table and
// u_dut3 with WAIT_CYC=3 for the latency and reset-in-WAIT sequences.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst3;

  dmem_responder_if bus1();
  dmem_responder_if bus3();

  dmem_responder #(.ADDR_W(10), .WAIT_CYC(1)) u_dut (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYC(3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] m);
    if (sel == 0) begin
      bus1.req_valid = v; bus1.req_addr = a; bus1.req_wdata = w; bus1.req_mask = m;
    end else begin
      bus3.req_valid = v; bus3.req_addr = a; bus3.req_wdata = w; bus3.req_mask = m;
    end
  endtask

  function automatic logic g_ready(input int sel);
    return (sel == 0) ? bus1.req_ready : bus3.req_ready;
  endfunction
  function automatic logic g_valid(input int sel);
    return (sel == 0) ? bus1.rsp_valid : bus3.rsp_valid;
  endfunction
  function automatic logic [31:0] g_rdata(input int sel);
    return (sel == 0) ? bus1.rsp_rdata : bus3.rsp_rdata;
  endfunction
  function automatic logic g_err(input int sel);
    return (sel == 0) ? bus1.rsp_err : bus3.rsp_err;
  endfunction

  // One full transaction with rsp_ready held high. lat counts clock edges
  // from presenting the request until rsp_valid is seen.
  task automatic txn(input int sel, input logic [31:0] a, input logic [31:0] w,
                     input logic [3:0] m, input bit scramble,
                     output logic [31:0] rd, output logic er, output int lat);
    check("req_ready_idle", 32'(g_ready(sel)), 32'd1);
    drive(sel, 1'b1, a, w, m);
    tick();
    lat = 1;
    if (scramble) drive(sel, 1'b0, a, ~w, ~m);
    else          drive(sel, 1'b0, a, w, m);
    check("req_ready_busy", 32'(g_ready(sel)), 32'd0);
    while (!g_valid(sel) && lat < 40) begin
      tick();
      lat++;
    end
    check("rsp_valid_seen", 32'(g_valid(sel)), 32'd1);
    rd = g_rdata(sel);
    er = g_err(sel);
    tick();
    check("rsp_valid_drop", 32'(g_valid(sel)), 32'd0);
    check("req_ready_after_rsp", 32'(g_ready(sel)), 32'd1);
    $display("txn dut%0d addr=%h wdata=%h mask=%b -> rdata=%h err=%0d lat=%0d",
             (sel == 0) ? 1 : 3, a, w, m, rd, er, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] held;

    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    bus1.rsp_ready = 1'b1;
    bus3.rsp_ready = 1'b1;
    rst1 = 1'b1;
    rst3 = 1'b1;

    // Reset state over two reset cycles.
    tick();
    check("rst_req_ready", 32'(bus1.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(bus1.rsp_err),   32'd0);
    check("rst_rsp_rdata", bus1.rsp_rdata,      32'h0);
    tick();
    check("rst_req_ready2", 32'(bus1.req_ready), 32'd0);
    check("rst3_req_ready", 32'(bus3.req_ready), 32'd0);
    check("rst3_rsp_valid", 32'(bus3.rsp_valid), 32'd0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(bus1.req_ready), 32'd1);

    // addr, wdata, mask, expected rdata, expected err
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0010, 32'h1122_3344, 4'b1111, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0010, 32'hAA5A_5A5A, 4'b1000, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0010, 32'h5A5A_BB5A, 4'b0010, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hAA22_BB44, 1'b0});
    vecs.push_back('{32'h0000_0010, 32'h5566_A5A5, 4'b1100, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0013, 32'h0000_0000, 4'b0000, 32'h5566_BB44, 1'b0});
    vecs.push_back('{32'h0000_001C, 32'h0102_0304, 4'b1111, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_001C, 32'hCAFE_F00D, 4'b0101, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_001C, 32'h0000_0000, 4'b0000, 32'h01FE_030D, 1'b0});
    vecs.push_back('{32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_1000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0000_0FFC, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0FFC, 32'h0000_0000, 4'b0000, 32'h1234_5678, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h8000_0010, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h5566_BB44, 1'b0});

    foreach (vecs[i]) begin
      txn(0, vecs[i].addr, vecs[i].wdata, vecs[i].mask, 1'b0, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
    end

    // Backpressure: response must hold for 5 cycles with rsp_ready low.
    bus1.rsp_ready = 1'b0;
    drive(0, 1'b1, 32'h0000_0010, 32'h0, 4'b0000);
    tick();
    drive(0, 1'b0, 32'h0000_0010, 32'h0, 4'b0000);
    lat = 1;
    while (!bus1.rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    held = bus1.rsp_rdata;
    check("bp_first_rdata", held, 32'h5566_BB44);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid_c%0d", k), 32'(bus1.rsp_valid), 32'd1);
      check($sformatf("bp_rdata_c%0d", k), bus1.rsp_rdata, 32'h5566_BB44);
      check($sformatf("bp_err_c%0d", k), 32'(bus1.rsp_err), 32'd0);
      check($sformatf("bp_ready_c%0d", k), 32'(bus1.req_ready), 32'd0);
      tick();
    end
    bus1.rsp_ready = 1'b1;
    tick();
    check("bp_req_ready_after", 32'(bus1.req_ready), 32'd1);
    check("bp_rsp_valid_after", 32'(bus1.rsp_valid), 32'd0);
    $display("txn dut1 addr=00000010 backpressure read held=%h", held);

    // Inputs changed right after acceptance must not affect the commit.
    txn(0, 32'h0000_0018, 32'h1357_9BDF, 4'b1111, 1'b1, rd, er, lat);
    check("scr_wr_err", 32'(er), 32'd0);
    txn(0, 32'h0000_0018, 32'h0, 4'b0000, 1'b0, rd, er, lat);
    check("scr_rd_rdata", rd, 32'h1357_9BDF);
    txn(0, 32'h0000_001C, 32'h0, 4'b0000, 1'b0, rd, er, lat);
    check("scr_neighbor", rd, 32'h01FE_030D);

    // WAIT_CYC=3 instance: latency and prior contents at 0x20.
    txn(1, 32'h0000_0020, 32'h0BAD_F00D, 4'b1111, 1'b0, rd, er, lat);
    check("w3_wr_lat", 32'(lat), 32'd4);
    txn(1, 32'h0000_0020, 32'h0, 4'b0000, 1'b0, rd, er, lat);
    check("w3_rd_rdata", rd, 32'h0BAD_F00D);
    check("w3_rd_lat", 32'(lat), 32'd4);

    // Reset while in WAIT abandons the write.
    drive(1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111);
    tick();
    drive(1, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111);
    tick();
    check("mid_wait_valid", 32'(bus3.rsp_valid), 32'd0);
    rst3 = 1'b1;
    #1;
    check("mid_rst_req_ready", 32'(bus3.req_ready), 32'd0);
    tick();
    check("mid_rst_valid", 32'(bus3.rsp_valid), 32'd0);
    tick();
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("mid_no_rsp_c%0d", k), 32'(bus3.rsp_valid), 32'd0);
      tick();
    end
    $display("txn dut3 addr=00000020 wdata=deadbeef mask=1111 abandoned by reset");
    txn(1, 32'h0000_0020, 32'h0, 4'b0000, 1'b0, rd, er, lat);
    check("mid_rd_prior", rd, 32'h0BAD_F00D);
    check("mid_rd_err", 32'(er), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
